// File: rtl/block_raster_writer_if.sv
// Block-in / RAM-write-out bundle for block_raster_writer.
// The master drives pixel blocks; the slave (the writer) drives the RAM port and status.
interface block_raster_writer_if #(
    parameter int TABLE_EDGE  = 8,
    parameter int PIXEL_WIDTH = 8,
    parameter int ADDR_WIDTH  = 17
);
    logic [TABLE_EDGE*TABLE_EDGE*PIXEL_WIDTH-1:0] table_in;
    logic                                         table_valid;
    logic                                         table_ready;
    logic [ADDR_WIDTH-1:0]                        ram_address;
    logic [PIXEL_WIDTH-1:0]                       ram_data;
    logic                                         ram_we;
    logic                                         busy;
    logic                                         frame_done;

    modport master (
        output table_in, table_valid,
        input  table_ready, ram_address, ram_data, ram_we, busy, frame_done
    );

    modport slave (
        input  table_in, table_valid,
        output table_ready, ram_address, ram_data, ram_we, busy, frame_done
    );
endinterface

// File: rtl/block_raster_writer.sv
// Scatters square pixel blocks into a planar image RAM, one pixel per cycle,
// walking blocks in raster order with all colour planes of a position interleaved.
module block_raster_writer #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int PIXEL_WIDTH  = 8,
    parameter int TABLE_EDGE   = 8,
    parameter int CHANNELS     = 1,
    parameter int ADDR_WIDTH   = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT*CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    block_raster_writer_if.slave  bus
);
    localparam int N_BX  = IMAGE_WIDTH / TABLE_EDGE;
    localparam int N_BY  = IMAGE_HEIGHT / TABLE_EDGE;
    localparam int BUF_W = TABLE_EDGE * TABLE_EDGE * PIXEL_WIDTH;
    localparam int T_W   = (TABLE_EDGE > 1) ? $clog2(TABLE_EDGE) : 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BX_W  = (N_BX > 1) ? $clog2(N_BX) : 1;
    localparam int BY_W  = (N_BY > 1) ? $clog2(N_BY) : 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                 state_q, state_d;
    logic [T_W-1:0]         tx_q, tx_d, ty_q, ty_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [BX_W-1:0]        bx_q, bx_d;
    logic [BY_W-1:0]        by_q, by_d;
    logic [BUF_W-1:0]       buf_q, buf_d;
    logic                   ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0]  ram_address_q, ram_address_d;
    logic [PIXEL_WIDTH-1:0] ram_data_q, ram_data_d;
    logic                   frame_done_q, frame_done_d;

    logic                   last_pix, accept;
    logic                   ch_wrap, bx_wrap, by_wrap;
    logic [CH_W-1:0]        ch_nxt;
    logic [BX_W-1:0]        bx_nxt;
    logic [BY_W-1:0]        by_nxt;
    logic [T_W-1:0]         tx_nxt, ty_nxt;

    // Address is formed wide and only then truncated, so odd ADDR_WIDTH overrides wrap cleanly.
    function automatic logic [ADDR_WIDTH-1:0] pixel_addr(
        input logic [CH_W-1:0] ch, input logic [BX_W-1:0] bx, input logic [BY_W-1:0] by,
        input logic [T_W-1:0] ty, input logic [T_W-1:0] tx);
        logic [63:0] a;
        a = 64'(ch) * 64'(IMAGE_WIDTH * IMAGE_HEIGHT)
          + (64'(by) * 64'(TABLE_EDGE) + 64'(ty)) * 64'(IMAGE_WIDTH)
          + 64'(bx) * 64'(TABLE_EDGE) + 64'(tx);
        return ADDR_WIDTH'(a);
    endfunction

    function automatic logic [PIXEL_WIDTH-1:0] pixel_at(
        input logic [BUF_W-1:0] blk, input logic [T_W-1:0] ty, input logic [T_W-1:0] tx);
        int idx;
        idx = (int'(ty) * TABLE_EDGE + int'(tx)) * PIXEL_WIDTH;
        return blk[idx +: PIXEL_WIDTH];
    endfunction

    assign last_pix = (state_q == WRITE) && (tx_q == T_W'(TABLE_EDGE - 1))
                   && (ty_q == T_W'(TABLE_EDGE - 1));

    // Ready is gated by rst so it drops the instant reset is asserted and rises on release.
    assign bus.table_ready = !rst && ((state_q == IDLE) || last_pix);
    assign accept          = bus.table_valid && bus.table_ready;

    assign ch_wrap = (ch_q == CH_W'(CHANNELS - 1));
    assign bx_wrap = (bx_q == BX_W'(N_BX - 1));
    assign by_wrap = (by_q == BY_W'(N_BY - 1));
    assign ch_nxt  = ch_wrap ? '0 : ch_q + CH_W'(1);
    assign bx_nxt  = !ch_wrap ? bx_q : (bx_wrap ? '0 : bx_q + BX_W'(1));
    assign by_nxt  = !(ch_wrap && bx_wrap) ? by_q : (by_wrap ? '0 : by_q + BY_W'(1));
    assign tx_nxt  = (tx_q == T_W'(TABLE_EDGE - 1)) ? '0 : tx_q + T_W'(1);
    assign ty_nxt  = (tx_q == T_W'(TABLE_EDGE - 1)) ? ty_q + T_W'(1) : ty_q;

    always_comb begin
        state_d       = state_q;
        tx_d          = tx_q;
        ty_d          = ty_q;
        ch_d          = ch_q;
        bx_d          = bx_q;
        by_d          = by_q;
        buf_d         = buf_q;
        ram_we_d      = 1'b0;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        frame_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d       = WRITE;
                    buf_d         = bus.table_in;
                    tx_d          = '0;
                    ty_d          = '0;
                    ram_we_d      = 1'b1;
                    ram_address_d = pixel_addr(ch_q, bx_q, by_q, '0, '0);
                    ram_data_d    = bus.table_in[PIXEL_WIDTH-1:0];
                end
            end
            WRITE: begin
                if (last_pix) begin
                    ch_d         = ch_nxt;
                    bx_d         = bx_nxt;
                    by_d         = by_nxt;
                    frame_done_d = ch_wrap && bx_wrap && by_wrap;
                    if (accept) begin
                        // Back-to-back block: pixel 0 comes straight from the input bus.
                        buf_d         = bus.table_in;
                        tx_d          = '0;
                        ty_d          = '0;
                        ram_we_d      = 1'b1;
                        ram_address_d = pixel_addr(ch_nxt, bx_nxt, by_nxt, '0, '0);
                        ram_data_d    = bus.table_in[PIXEL_WIDTH-1:0];
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tx_d          = tx_nxt;
                    ty_d          = ty_nxt;
                    ram_we_d      = 1'b1;
                    ram_address_d = pixel_addr(ch_q, bx_q, by_q, ty_nxt, tx_nxt);
                    ram_data_d    = pixel_at(buf_q, ty_nxt, tx_nxt);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            tx_q          <= '0;
            ty_q          <= '0;
            ch_q          <= '0;
            bx_q          <= '0;
            by_q          <= '0;
            ram_we_q      <= 1'b0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_q          <= tx_d;
            ty_q          <= ty_d;
            ch_q          <= ch_d;
            bx_q          <= bx_d;
            by_q          <= by_d;
            ram_we_q      <= ram_we_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // Pixel buffer is pure data and needs no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign bus.ram_we      = ram_we_q;
    assign bus.ram_address = ram_address_q;
    assign bus.ram_data    = ram_data_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.busy        = (state_q == WRITE);
endmodule

// File: doc/block_raster_writer.md
BLOCK_RASTER_WRITER -- requirements
Module: block_raster_writer

Interface
- REQ-001 The module SHALL have parameter IMAGE_WIDTH, default 320: image width in pixels, a multiple of TABLE_EDGE.
- REQ-002 The module SHALL have parameter IMAGE_HEIGHT, default 240: image height in pixels, a multiple of TABLE_EDGE.
- REQ-003 The module SHALL have parameter PIXEL_WIDTH, default 8: bits per pixel.
- REQ-004 The module SHALL have parameter TABLE_EDGE, default 8: block edge in pixels; table holds TABLE_EDGE*TABLE_EDGE pixels.
- REQ-005 The module SHALL have parameter CHANNELS, default 1, range 1..4: colour planes per frame.
- REQ-006 The module SHALL have parameter ADDR_WIDTH, default clog2(IMAGE_WIDTH*IMAGE_HEIGHT*CHANNELS): RAM address width.
- REQ-007 Ports SHALL be:
  - clk  in  1  clock; one clock domain; all state on rising edge.
  - rst  in  1  reset; asynchronous, active-high.
  - table_in  in  TABLE_EDGE*TABLE_EDGE*PIXEL_WIDTH  pixel block; element i = row*TABLE_EDGE+col at bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
  - table_valid  in  1  table_in is valid.
  - table_ready  out  1  block can be accepted.
  - ram_address  out  ADDR_WIDTH  image RAM write address.
  - ram_data  out  PIXEL_WIDTH  image RAM write data.
  - ram_we  out  1  image RAM write enable.
  - busy  out  1  block being written.
  - frame_done  out  1  one-cycle pulse after the last write of a frame.

Function
- REQ-008 A block SHALL be accepted on a rising edge where table_valid and table_ready are both 1; table_in SHALL be captured into an internal buffer on that edge.
- REQ-009 The FSM SHALL have two states: IDLE (table_ready=1, busy=0) and WRITE (busy=1).
- REQ-010 On acceptance in IDLE, the FSM SHALL go to WRITE with pixel index 0.
- REQ-011 In WRITE, the block SHALL issue one write per cycle for TABLE_EDGE*TABLE_EDGE consecutive cycles, in row-major order (tx fastest, then ty).
- REQ-012 The first ram_we=1 cycle SHALL be the cycle immediately after the accepting edge.
- REQ-013 table_ready SHALL be 1 in WRITE only during the final pixel's cycle. An acceptance on that edge SHALL keep the FSM in WRITE with pixel index 0, giving gap-free back-to-back blocks.
- REQ-014 After the final pixel with no acceptance, the FSM SHALL return to IDLE; ram_we SHALL then be 0.
- REQ-015 ram_address SHALL be ch*IMAGE_WIDTH*IMAGE_HEIGHT + (by*TABLE_EDGE+ty)*IMAGE_WIDTH + bx*TABLE_EDGE + tx (planar layout), computed to full precision and truncated to ADDR_WIDTH.
- REQ-016 ram_data SHALL be buffer element ty*TABLE_EDGE+tx. ram_address, ram_data and ram_we SHALL be registered outputs.
- REQ-017 Block order SHALL be interleaved per position: for each (by, bx) in raster order, channels 0..CHANNELS-1.
- REQ-018 After each block's final write, ch SHALL advance:
  - ch wraps to 0 after CHANNELS-1, then bx advances;
  - bx wraps to 0 after IMAGE_WIDTH/TABLE_EDGE-1, then by advances;
  - by wraps to 0 after IMAGE_HEIGHT/TABLE_EDGE-1.
- REQ-019 When all three counters wrap together, frame_done SHALL pulse for exactly one cycle, in the cycle following the final write. This SHALL hold even if the next frame's first block is accepted back-to-back.
- REQ-020 table_in changes while not accepted SHALL have no effect; table_valid held high in WRITE SHALL not be accepted except per REQ-013.

Reset
- REQ-021 Reset SHALL force, immediately and independent of clk:
  - FSM to IDLE;
  - ch, bx, by, tx, ty to 0;
  - ram_we=0, ram_address=0, ram_data=0;
  - busy=0, frame_done=0.
- REQ-022 table_ready SHALL be 0 while rst=1 and 1 on the first cycle after release.
- REQ-023 Reset during WRITE SHALL abort the block with no further writes. The next accepted block SHALL be treated as block (0,0), channel 0.

Verification (W=16, H=16, E=8, PIXEL_WIDTH=8 unless stated)
- REQ-024 CHANNELS=1, one block with element i = i:
  - ram_we is high for 64 cycles starting 1 cycle after acceptance;
  - addresses run 0..7, 16..23, ..., 112..119;
  - data runs 0..63.
- REQ-025 CHANNELS=1, four blocks sent back-to-back with table_valid held high:
  - 256 contiguous write cycles with no gap;
  - block 1 starts at address 8, block 2 at 128, block 3 at 136;
  - last address is 255;
  - frame_done pulses once, one cycle after that write.
- REQ-026 CHANNELS=3, twelve blocks:
  - first addresses are 0, 256, 512, then 8, ...;
  - final write is to address 767, then frame_done pulses;
  - a 13th block starts at address 0.
- REQ-027 Assert rst at pixel 30 of block 1:
  - ram_we falls immediately;
  - after release, table_ready=1;
  - the next block writes from address 0.
- REQ-028 table_valid toggled randomly, including during WRITE:
  - acceptances occur only when table_ready=1;
  - the write count equals 64 × the number of handshakes;
  - no duplicate addresses within a frame.
